fetch_unit: RTL

Instruction fetch stage for the RISC-V core, directly upstream of the control unit and datapath. It owns the PC register and issues word reads to instruction memory with one request outstanding. It holds the current instruction, plus one prefetched successor, for the decode stage. It decodes the op, funct3 and funct7 fields for the control unit, and applies redirects driven by PCSrc/PCTarget.

---
 rtl/fetch_unit_if.sv | 32 +++
 rtl/fetch_unit.sv | 134 +++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Bundles the instruction-memory bus and the decode-side handshake of the fetch stage.
// The master modport is the fetch unit; the slave modport is memory plus decode.
interface fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [6:0]  op;
   logic [2:0]  funct3;
   logic        funct7;
   logic        instr_ready;
   logic        PCSrc;
   logic [31:0] PCTarget;

   modport master (
      output imem_req, imem_addr,
      input  imem_ready, imem_rdata,
      output instr_valid, instr, pc, pc_plus4, op, funct3, funct7,
      input  instr_ready, PCSrc, PCTarget
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ready, imem_rdata,
      input  instr_valid, instr, pc, pc_plus4, op, funct3, funct7,
      output instr_ready, PCSrc, PCTarget
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one memory read in flight, and buffers
// the current instruction plus one prefetched successor for decode.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          reset_n,
   fetch_unit_if.master  bus
);

   typedef enum logic [1:0] {REQ_IDLE, REQ_BUSY, REQ_SQUASH} req_state_t;

   req_state_t  req_state, req_state_next;
   logic [31:0] req_pc;
   logic [31:0] fetch_pc;

   logic        hold_valid;
   logic [31:0] hold_instr;
   logic [31:0] hold_pc;
   logic [31:0] hold_pc_plus4;

   logic        pf_valid;
   logic [31:0] pf_instr;
   logic [31:0] pf_pc;

   logic        pending, squash, consume, redirect, resp, resp_ok, issue;
   logic [1:0]  slots_next;
   logic [31:0] target, issue_addr;

   assign pending  = (req_state != REQ_IDLE);
   assign squash   = (req_state == REQ_SQUASH);
   assign consume  = hold_valid & bus.instr_ready;
   assign redirect = consume & bus.PCSrc;
   assign resp     = pending & bus.imem_ready;
   assign resp_ok  = resp & ~squash & ~redirect;
   assign target   = {bus.PCTarget[31:2], 2'b00};

   // A new request is only issued if its word will have a slot once this cycle settles,
   // counting the response that lands now; this is what caps backpressure at one prefetch.
   always_comb begin
      slots_next = 2'd0;
      issue_addr = fetch_pc;
      if (!redirect) begin
         slots_next = {1'b0, hold_valid} + {1'b0, pf_valid} + {1'b0, resp_ok} - {1'b0, consume};
      end else begin
         issue_addr = target;
      end
      issue = (!pending || resp) && (slots_next < 2'd2);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         req_state <= REQ_IDLE;
      end else begin
         req_state <= req_state_next;
      end
   end

   always_comb begin
      req_state_next = req_state;
      case (req_state)
         REQ_IDLE: begin
            if (issue) req_state_next = REQ_BUSY;
         end
         REQ_BUSY: begin
            if (resp)          req_state_next = issue ? REQ_BUSY : REQ_IDLE;
            else if (redirect) req_state_next = REQ_SQUASH;
         end
         REQ_SQUASH: begin
            if (resp) req_state_next = issue ? REQ_BUSY : REQ_IDLE;
         end
         default: req_state_next = REQ_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         req_pc   <= RESET_PC;
         fetch_pc <= RESET_PC;
      end else if (issue) begin
         req_pc   <= issue_addr;
         fetch_pc <= issue_addr + 32'd4;
      end else if (redirect) begin
         fetch_pc <= target;
      end
   end

   // Hold always carries the oldest word; pf only ever receives the word right behind it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_valid    <= 1'b0;
         hold_instr    <= 32'h0000_0013;
         hold_pc       <= RESET_PC;
         hold_pc_plus4 <= RESET_PC + 32'd4;
         pf_valid      <= 1'b0;
         pf_instr      <= 32'h0000_0000;
         pf_pc         <= RESET_PC;
      end else if (redirect) begin
         hold_valid <= 1'b0;
         pf_valid   <= 1'b0;
      end else if (consume && pf_valid) begin
         hold_instr    <= pf_instr;
         hold_pc       <= pf_pc;
         hold_pc_plus4 <= pf_pc + 32'd4;
         pf_valid      <= resp_ok;
         if (resp_ok) begin
            pf_instr <= bus.imem_rdata;
            pf_pc    <= req_pc;
         end
      end else if (resp_ok && (consume || !hold_valid)) begin
         hold_valid    <= 1'b1;
         hold_instr    <= bus.imem_rdata;
         hold_pc       <= req_pc;
         hold_pc_plus4 <= req_pc + 32'd4;
      end else if (resp_ok) begin
         pf_valid <= 1'b1;
         pf_instr <= bus.imem_rdata;
         pf_pc    <= req_pc;
      end else if (consume) begin
         hold_valid <= 1'b0;
      end
   end

   assign bus.imem_req    = pending;
   assign bus.imem_addr   = req_pc;
   assign bus.instr_valid = hold_valid;
   assign bus.instr       = hold_instr;
   assign bus.pc          = hold_pc;
   assign bus.pc_plus4    = hold_pc_plus4;
   assign bus.op          = hold_instr[6:0];
   assign bus.funct3      = hold_instr[14:12];
   assign bus.funct7      = hold_instr[30];

endmodule
